// File: rtl/alu_issue_ctrl_if.sv
// Command/response handshake bundle for alu_issue_ctrl.
// cmd_use_acc exists only when ALU_ACC_CHAIN_EN is defined.
interface alu_issue_ctrl_if #(
  parameter int n = 8
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [n-1:0] cmd_a;
  logic [n-1:0] cmd_b;
`ifdef ALU_ACC_CHAIN_EN
  logic         cmd_use_acc;
`endif
  logic         rsp_valid;
  logic         rsp_ready;
  logic [n-1:0] rsp_result;
  logic         rsp_z;
  logic         rsp_c;
  logic         rsp_cout;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
`ifdef ALU_ACC_CHAIN_EN
    output cmd_use_acc,
`endif
    output rsp_ready,
    input  cmd_ready, rsp_valid,
    input  rsp_result, rsp_z, rsp_c, rsp_cout
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
`ifdef ALU_ACC_CHAIN_EN
    input  cmd_use_acc,
`endif
    input  rsp_ready,
    output cmd_ready, rsp_valid,
    output rsp_result, rsp_z, rsp_c, rsp_cout
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one command at a time to a combinational ALU and holds its response.
// Optional accumulator chaining via macro ALU_ACC_CHAIN_EN.
module alu_issue_ctrl #(
  parameter int n = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_issue_ctrl_if.slave bus,
  output logic [n-1:0]   alu_a,
  output logic [n-1:0]   alu_b,
  output logic [2:0]     alu_opcode,
  input  logic [n-1:0]   alu_result,
  input  logic           alu_z,
  input  logic           alu_c,
  input  logic           alu_cout,
  output logic [15:0]    op_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic         accept;
  logic         capture;
  logic         fire;
  logic [n-1:0] a_sel;

`ifdef ALU_ACC_CHAIN_EN
  logic [n-1:0] acc_q;
`endif

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-edge strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          fire    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand A source: command or chained accumulator
  always_comb begin
    a_sel = bus.cmd_a;
`ifdef ALU_ACC_CHAIN_EN
    if (bus.cmd_use_acc) a_sel = acc_q;
`endif
  end

  // Operand/opcode registers, held until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= 3'b000;
    end else if (accept) begin
      alu_a      <= a_sel;
      alu_b      <= bus.cmd_b;
      alu_opcode <= bus.cmd_op;
    end
  end

  // Response capture after one full settle cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_result <= '0;
      bus.rsp_z      <= 1'b0;
      bus.rsp_c      <= 1'b0;
      bus.rsp_cout   <= 1'b0;
    end else if (capture) begin
      bus.rsp_result <= alu_result;
      bus.rsp_z      <= alu_z;
      bus.rsp_c      <= alu_c;
      bus.rsp_cout   <= alu_cout;
    end
  end

  // Saturating count of completed responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_count <= '0;
    else if (fire && op_count != 16'hFFFF)
      op_count <= op_count + 16'd1;
  end

`ifdef ALU_ACC_CHAIN_EN
  // Accumulator follows every captured result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       acc_q <= '0;
    else if (capture) acc_q <= alu_result;
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU stand-in.
// Randomized commands are checked against a reference model.
module tb_alu_issue_ctrl;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   alu_a;
  logic [N-1:0]   alu_b;
  logic [2:0]     alu_opcode;
  logic [N-1:0]   alu_result;
  logic           alu_z;
  logic           alu_c;
  logic           alu_cout;
  logic [15:0]    op_count;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;
  logic [N-1:0] acc_m = '0;

  alu_issue_ctrl_if #(.n(N)) bus();

  alu_issue_ctrl #(.n(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_z      (alu_z),
    .alu_c      (alu_c),
    .alu_cout   (alu_cout),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  // Returns {z, c, cout, result}
  function automatic logic [N+2:0] ref_alu(
    input logic [2:0]   op,
    input logic [N-1:0] a,
    input logic [N-1:0] b
  );
    logic [N:0] w;
    case (op)
      3'd0: w = {1'b0, a} + {1'b0, b};
      3'd1: w = {1'b0, a} - {1'b0, b};
      3'd2: w = {1'b0, a & b};
      3'd3: w = {1'b0, a | b};
      3'd4: w = {1'b0, a ^ b};
      3'd5: w = (a > b) ? (N+1)'(1) : '0;
      3'd6: w = {a, 1'b0};
      default: w = {b, 1'b0};
    endcase
    return {(w[N-1:0] == '0), w[N], w[N], w[N-1:0]};
  endfunction

  always_comb
    {alu_z, alu_c, alu_cout, alu_result} =
      ref_alu(alu_opcode, alu_a, alu_b);

  task automatic drive_idle();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
`ifdef ALU_ACC_CHAIN_EN
    bus.cmd_use_acc = 1'b0;
`endif
    bus.rsp_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string nm);
    tests++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 ||
        alu_a !== '0 || alu_b !== '0 || alu_opcode !== 3'b000 ||
        bus.rsp_result !== '0 || bus.rsp_z !== 1'b0 ||
        bus.rsp_c !== 1'b0 || bus.rsp_cout !== 1'b0 ||
        op_count !== 16'd0) begin
      fails++;
      $display("FAIL %s: rdy=%b vld=%b a=%h b=%h op=%h res=%h zccout=%b%b%b cnt=%0d, required all reset values",
               nm, bus.cmd_ready, bus.rsp_valid, alu_a, alu_b, alu_opcode,
               bus.rsp_result, bus.rsp_z, bus.rsp_c, bus.rsp_cout, op_count);
    end
  endtask

  // Full command/response transaction; starts and ends at a negedge
  task automatic run_cmd(
    input logic [2:0]   op,
    input logic [N-1:0] a,
    input logic [N-1:0] b,
    input logic         ua,
    input int           hold,
    input string        nm
  );
    logic [N-1:0] ea;
    logic [N+2:0] e;
    logic [N+2:0] got;
    ea = a;
`ifdef ALU_ACC_CHAIN_EN
    if (ua) ea = acc_m;
`endif
    e = ref_alu(op, ea, b);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
`ifdef ALU_ACC_CHAIN_EN
    bus.cmd_use_acc = ua;
`endif
    bus.rsp_ready = 1'($urandom_range(0, 1));
    tests++;
    if (bus.cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s accept_ready: cmd_ready=%b required 1 (op=%0d ua=%b)",
               nm, bus.cmd_ready, op, ua);
    end
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'($urandom_range(0, 1));
    tests++;
    if (alu_a !== ea || alu_b !== b || alu_opcode !== op ||
        bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s exec: a=%h b=%h op=%0d vld=%b rdy=%b required a=%h b=%h op=%0d vld=0 rdy=0",
               nm, alu_a, alu_b, alu_opcode, bus.rsp_valid, bus.cmd_ready,
               ea, b, op);
    end
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    got = {bus.rsp_z, bus.rsp_c, bus.rsp_cout, bus.rsp_result};
    tests++;
    if (bus.rsp_valid !== 1'b1 || got !== e) begin
      fails++;
      $display("FAIL %s resp: vld=%b zccout_res=%h required vld=1 zccout_res=%h",
               nm, bus.rsp_valid, got, e);
    end
    acc_m = e[N-1:0];
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 3'($urandom);
      bus.cmd_a     = N'($urandom);
      bus.cmd_b     = N'($urandom);
      @(posedge clk);
      @(negedge clk);
      got = {bus.rsp_z, bus.rsp_c, bus.rsp_cout, bus.rsp_result};
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0 ||
          got !== e || alu_a !== ea || alu_b !== b || alu_opcode !== op) begin
        fails++;
        $display("FAIL %s hold%0d: vld=%b rdy=%b res=%h a=%h required vld=1 rdy=0 res=%h a=%h",
                 nm, i, bus.rsp_valid, bus.cmd_ready, got, alu_a, e, ea);
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    if (exp_cnt < 65535) exp_cnt++;
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 ||
        op_count !== exp_cnt[15:0]) begin
      fails++;
      $display("FAIL %s done: vld=%b rdy=%b cnt=%0d required vld=0 rdy=1 cnt=%0d",
               nm, bus.rsp_valid, bus.cmd_ready, op_count, exp_cnt);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset_state");
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    run_cmd(3'b000, 8'd200, 8'd100, 1'b0, 0, "add_200_100");
    run_cmd(3'b001, 8'd5, 8'd5, 1'b0, 0, "sub_5_5");
    run_cmd(3'b110, 8'h81, 8'h00, 1'b0, 0, "shl_a_81");
    run_cmd(3'b111, 8'h7F, 8'hC0, 1'b0, 0, "shl_b_c0");
    run_cmd(3'b101, 8'h10, 8'h0F, 1'b0, 0, "gt_10_0f");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_cmd(3'($urandom), N'($urandom), N'($urandom),
              1'($urandom_range(0, 1)), $urandom_range(0, 2), "random");
  endtask

  task automatic test_backpressure();
    run_cmd(3'b100, 8'hA5, 8'h3C, 1'b0, 10, "backpressure");
  endtask

  task automatic test_reset_midflight();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'b000;
    bus.cmd_a     = 8'd9;
    bus.cmd_b     = 8'd9;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_in_exec");
    exp_cnt = 0;
    acc_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (bus.rsp_valid !== 1'b0 || op_count !== 16'd0) begin
        fails++;
        $display("FAIL post_reset%0d: vld=%b cnt=%0d required vld=0 cnt=0",
                 i, bus.rsp_valid, op_count);
      end
    end
    run_cmd(3'b011, 8'h0F, 8'hF0, 1'b0, 0, "after_reset");
  endtask

  task automatic test_saturation();
    force dut.op_count = 16'hFFFD;
    @(negedge clk);
    release dut.op_count;
    exp_cnt = 65533;
    for (int i = 0; i < 4; i++)
      run_cmd(3'($urandom), N'($urandom), N'($urandom), 1'b0, 0, "saturate");
  endtask

`ifdef ALU_ACC_CHAIN_EN
  task automatic test_acc_chain();
    run_cmd(3'b000, 8'd3, 8'd4, 1'b0, 0, "acc_load");
    run_cmd(3'b000, 8'd99, 8'd10, 1'b1, 0, "acc_use");
    tests++;
    if (bus.rsp_result !== 8'd17) begin
      fails++;
      $display("FAIL acc_chain: result=%0d required 17", bus.rsp_result);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_random();
`ifdef ALU_ACC_CHAIN_EN
    test_acc_chain();
`endif
    test_reset_midflight();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
